led_s2p_receiver: RTL

//   Serial-to-parallel receiver for the LED serial link (sclk/sclrn/sout/PEN).

---
 rtl/led_link_pkg.sv | 19 +
 rtl/led_link_sync.sv | 39 +++
 rtl/led_s2p_receiver.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/led_link_pkg.sv
// Shared types and constants for the LED serial link receiver.
package led_link_pkg;

    localparam int SYNC_STAGES = 2;

    // Bit positions of the link signals inside the packed synchroniser bus.
    localparam int LINK_WIDTH = 4;
    localparam int IDX_CLK    = 0;
    localparam int IDX_SOUT   = 1;
    localparam int IDX_CLRN   = 2;
    localparam int IDX_PEN    = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        OVF   = 2'd2
    } s2p_state_t;

endpackage

// File: rtl/led_link_sync.sv
// Two-flop synchroniser followed by a delay stage; level, rise and fall are all
// registered so they line up with each other one cycle after the second flop.
module led_link_sync
    import led_link_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
)(
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   delay_reg;
    logic                   rise_reg;
    logic                   fall_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_reg  <= {SYNC_STAGES{RESET_VAL}};
            delay_reg <= RESET_VAL;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[SYNC_STAGES-2:0], din};
            delay_reg <= sync_reg[SYNC_STAGES-1];
            rise_reg  <= sync_reg[SYNC_STAGES-1] & ~delay_reg;
            fall_reg  <= ~sync_reg[SYNC_STAGES-1] & delay_reg;
        end
    end

    assign level = delay_reg;
    assign rise  = rise_reg;
    assign fall  = fall_reg;

endmodule

// File: rtl/led_s2p_receiver.sv
// Board-side serial-to-parallel receiver for the LED chain link.
// Optional mid-frame watchdog enabled by defining LED_S2P_TIMEOUT_EN.
module led_s2p_receiver
    import led_link_pkg::*;
#(
    parameter  int DATA_BITS = 16,
    parameter  bit INVERT    = 1'b1,
    parameter  int TIMEOUT   = 1024,
    localparam int CW        = $clog2(DATA_BITS + 1)
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_clk,
    input  logic                 s_sout,
    input  logic                 s_clrn,
    input  logic                 s_pen,
    output logic [DATA_BITS-1:0] PData,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy,
    output logic [CW-1:0]        bit_cnt
);

    // s_clrn idles high, everything else idles low.
    localparam logic [LINK_WIDTH-1:0] SYNC_RST = 4'b0100;

    logic [LINK_WIDTH-1:0] raw_bus;
    logic [LINK_WIDTH-1:0] lvl_bus;
    logic [LINK_WIDTH-1:0] rise_bus;
    logic [LINK_WIDTH-1:0] fall_bus;

    assign raw_bus[IDX_CLK]  = s_clk;
    assign raw_bus[IDX_SOUT] = s_sout;
    assign raw_bus[IDX_CLRN] = s_clrn;
    assign raw_bus[IDX_PEN]  = s_pen;

    genvar gi;
    generate
        for (gi = 0; gi < LINK_WIDTH; gi++) begin : g_sync
            led_link_sync #(
                .RESET_VAL (SYNC_RST[gi])
            ) u_sync (
                .clk   (clk),
                .rst   (rst),
                .din   (raw_bus[gi]),
                .level (lvl_bus[gi]),
                .rise  (rise_bus[gi]),
                .fall  (fall_bus[gi])
            );
        end
    endgenerate

    logic clk_rise;
    logic sout_lvl;
    logic clrn_lvl;
    logic pen_rise;

    assign clk_rise = rise_bus[IDX_CLK];
    assign sout_lvl = lvl_bus[IDX_SOUT];
    assign clrn_lvl = lvl_bus[IDX_CLRN];
    assign pen_rise = rise_bus[IDX_PEN];

    logic unused_sync_taps;
    assign unused_sync_taps = ^{fall_bus, rise_bus[IDX_SOUT], rise_bus[IDX_CLRN],
                                lvl_bus[IDX_CLK], lvl_bus[IDX_PEN]};

    s2p_state_t           state_reg,  state_next;
    logic [DATA_BITS-1:0] shreg_reg,  shreg_next;
    logic [DATA_BITS-1:0] pdata_reg,  pdata_next;
    logic [CW-1:0]        cnt_reg,    cnt_next;
    logic                 valid_reg,  valid_next;
    logic                 err_reg,    err_next;

`ifdef LED_S2P_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT + 1);
    logic [WW-1:0]        wd_reg,     wd_next;
`else
    localparam int unused_timeout = TIMEOUT;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
            shreg_reg <= '0;
            pdata_reg <= '0;
            cnt_reg   <= '0;
            valid_reg <= 1'b0;
            err_reg   <= 1'b0;
`ifdef LED_S2P_TIMEOUT_EN
            wd_reg    <= '0;
`endif
        end else begin
            state_reg <= state_next;
            shreg_reg <= shreg_next;
            pdata_reg <= pdata_next;
            cnt_reg   <= cnt_next;
            valid_reg <= valid_next;
            err_reg   <= err_next;
`ifdef LED_S2P_TIMEOUT_EN
            wd_reg    <= wd_next;
`endif
        end
    end

    // Clear beats frame end, frame end beats a data edge.
    always_comb begin
        state_next = state_reg;
        shreg_next = shreg_reg;
        pdata_next = pdata_reg;
        cnt_next   = cnt_reg;
        valid_next = 1'b0;
        err_next   = 1'b0;
`ifdef LED_S2P_TIMEOUT_EN
        wd_next    = wd_reg;
`endif
        if (!clrn_lvl) begin
            state_next = IDLE;
            shreg_next = '0;
            cnt_next   = '0;
`ifdef LED_S2P_TIMEOUT_EN
            wd_next    = '0;
`endif
        end else if (pen_rise) begin
            case (state_reg)
                SHIFT: begin
                    if (cnt_reg == CW'(DATA_BITS)) begin
                        pdata_next = INVERT ? ~shreg_reg : shreg_reg;
                        valid_next = 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                end
                OVF:     err_next = 1'b1;
                default: ;
            endcase
            state_next = IDLE;
            shreg_next = '0;
            cnt_next   = '0;
`ifdef LED_S2P_TIMEOUT_EN
            wd_next    = '0;
`endif
        end else if (clk_rise) begin
            case (state_reg)
                IDLE: begin
                    shreg_next = {{(DATA_BITS-1){1'b0}}, sout_lvl};
                    cnt_next   = CW'(1);
                    state_next = SHIFT;
                end
                SHIFT: begin
                    // A bit beyond the frame width is dropped, not shifted.
                    if (cnt_reg == CW'(DATA_BITS)) begin
                        state_next = OVF;
                    end else begin
                        shreg_next = {shreg_reg[DATA_BITS-2:0], sout_lvl};
                        cnt_next   = cnt_reg + CW'(1);
                    end
                end
                default: ;
            endcase
`ifdef LED_S2P_TIMEOUT_EN
            wd_next = '0;
`endif
        end
`ifdef LED_S2P_TIMEOUT_EN
        else if (state_reg != IDLE) begin
            if (wd_reg == WW'(TIMEOUT - 1)) begin
                err_next   = 1'b1;
                state_next = IDLE;
                shreg_next = '0;
                cnt_next   = '0;
                wd_next    = '0;
            end else begin
                wd_next = wd_reg + WW'(1);
            end
        end
`endif
    end

    assign PData     = pdata_reg;
    assign valid     = valid_reg;
    assign frame_err = err_reg;
    assign busy      = (state_reg != IDLE);
    assign bit_cnt   = cnt_reg;

endmodule
